pb_debouncer_multi: RTL and testbench

- Parametrised N-channel push-button conditioner; successor to the single-channel debouncer used on board buttons.
- Per channel: 2-FF synchroniser, debounce filter of DELAY stable cycles, clean level, press/release pulses.
- Adds long-press detection and optional auto-repeat pulses while held.
- Sits between raw board buttons and FSM/UI logic. All channels are fully independent.

---
 rtl/pb_debouncer_multi.sv | 179 +++++++++++++++++
 tb/tb_pb_debouncer_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debouncer_multi.sv
// ----------------------------------------------------------------------------
// pb_debouncer_multi
//
// N-channel push-button conditioner. Each channel is independent and has:
//   - a 2-flop synchroniser on the (optionally inverted) raw input
//   - a debounce filter that toggles the clean level only after the
//     synchronised input has disagreed with it for DELAY consecutive cycles
//   - one-cycle press / release pulses aligned with the level change
//   - long-press detection LONG_CYCLES cycles after the press pulse
//   - optional auto-repeat pulses every REPEAT_CYCLES after the long press
//
// Ports:
//   clk                : base clock, rising edge
//   rst                : asynchronous active-low reset
//   PB                 : raw asynchronous button inputs
//   PB_pressed_status  : debounced level, 1 = pressed
//   PB_pressed_pulse   : one-cycle pulse on debounced press
//   PB_released_pulse  : one-cycle pulse on debounced release
//   PB_long_pulse      : one-cycle pulse when the hold reaches LONG_CYCLES
//   PB_repeat_pulse    : one-cycle auto-repeat pulses while held
//   PB_long_status     : 1 from the long pulse until the debounced release
// ----------------------------------------------------------------------------
module pb_debouncer_multi #(
    parameter int N_CH          = 4,
    parameter int DELAY         = 15,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] PB_pressed_status,
    output logic [N_CH-1:0] PB_pressed_pulse,
    output logic [N_CH-1:0] PB_released_pulse,
    output logic [N_CH-1:0] PB_long_pulse,
    output logic [N_CH-1:0] PB_repeat_pulse,
    output logic [N_CH-1:0] PB_long_status
);

    localparam int DB_W   = $clog2(DELAY);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    // A single-cycle repeat period still needs a one-bit counter to exist.
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic              INVERT    = (ACTIVE_LOW != 0);

    // Illegal parameter sets are rejected while elaborating.
    if (N_CH < 1) begin : g_bad_nch
        $error("pb_debouncer_multi: N_CH must be >= 1");
    end
    if (DELAY < 2) begin : g_bad_delay
        $error("pb_debouncer_multi: DELAY must be >= 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("pb_debouncer_multi: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("pb_debouncer_multi: REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              sync_meta;
        logic              sync_q;
        logic              status_q;
        logic [DB_W-1:0]   db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        logic              pressed_q;
        logic              released_q;
        logic              long_q;
        logic              repeat_q;
        logic              long_status_q;

        logic              toggle;
        logic              rise;
        logic              fall;
        logic              long_hit;
        logic              repeat_hit;

        // Events decided this cycle that take effect at the next edge.
        // A falling level wins over any long or repeat pulse due at the
        // same edge, so both hit terms are masked by fall.
        always_comb begin
            toggle     = (sync_q != status_q) && (db_cnt == DB_LAST);
            rise       = toggle && !status_q;
            fall       = toggle && status_q;
            long_hit   = status_q && !fall && (hold_cnt == HOLD_FIRE);
            repeat_hit = (REPEAT_EN != 0) && long_status_q && status_q &&
                         !fall && (rep_cnt == REP_LAST);
        end

        // Two-flop synchroniser on the polarity-corrected raw input.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_meta <= 1'b0;
                sync_q    <= 1'b0;
            end else begin
                sync_meta <= PB[i] ^ INVERT;
                sync_q    <= sync_meta;
            end
        end

        // Debounce filter: the counter only runs while the synchronised
        // input disagrees with the clean level; any agreement restarts it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_cnt   <= '0;
                status_q <= 1'b0;
            end else if (sync_q == status_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                status_q <= ~status_q;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        // Hold counter: zero in the press-pulse cycle, saturates so the
        // long pulse can only fire once per press.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_cnt <= '0;
            end else if (!status_q || fall) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end

        // Repeat counter runs only after the long press and wraps forever.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rep_cnt <= '0;
            end else if (!long_status_q || fall) begin
                rep_cnt <= '0;
            end else if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end

        // Registered event outputs, aligned with the level change.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pressed_q     <= 1'b0;
                released_q    <= 1'b0;
                long_q        <= 1'b0;
                repeat_q      <= 1'b0;
                long_status_q <= 1'b0;
            end else begin
                pressed_q  <= rise;
                released_q <= fall;
                long_q     <= long_hit;
                repeat_q   <= repeat_hit;
                if (fall) begin
                    long_status_q <= 1'b0;
                end else if (long_hit) begin
                    long_status_q <= 1'b1;
                end
            end
        end

        assign PB_pressed_status[i] = status_q;
        assign PB_pressed_pulse[i]  = pressed_q;
        assign PB_released_pulse[i] = released_q;
        assign PB_long_pulse[i]     = long_q;
        assign PB_repeat_pulse[i]   = repeat_q;
        assign PB_long_status[i]    = long_status_q;
    end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// ----------------------------------------------------------------------------
// tb_pb_debouncer_multi
//
// Two instances of pb_debouncer_multi with small timing parameters:
//   dut_a : active-high inputs, auto-repeat enabled
//   dut_b : active-low inputs, auto-repeat disabled
// Each directed step drives the inputs and pushes the expected outputs of
// both instances onto a queue; the outputs are popped and compared at the
// falling clock edge. Expected values come from event times derived from
// the button edge times (press/release seen 2+DELAY cycles after the edge,
// long LONG_CYCLES after the press, repeats every REPEAT_CYCLES after long).
// ----------------------------------------------------------------------------
module tb_pb_debouncer_multi;

    localparam int N_CH          = 2;
    localparam int DELAY         = 4;
    localparam int LONG_CYCLES   = 20;
    localparam int REPEAT_CYCLES = 8;
    localparam int PRESS_LAT     = 2 + DELAY;
    localparam int NEVER         = 1000000;
    localparam logic [5:0]  IDLE_CH  = 6'b0;
    localparam logic [11:0] ALL_ZERO = 12'b0;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] pb_a;
    logic [N_CH-1:0] pb_b;

    logic [N_CH-1:0] a_status, a_pressed, a_released, a_long, a_repeat, a_long_status;
    logic [N_CH-1:0] b_status, b_pressed, b_released, b_long, b_repeat, b_long_status;
    logic [11:0]     obs_a;
    logic [11:0]     obs_b;

    exp_t exp_q[$];
    int   tests_run  = 0;
    int   fail_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pb_debouncer_multi #(
        .N_CH(N_CH), .DELAY(DELAY), .LONG_CYCLES(LONG_CYCLES),
        .REPEAT_EN(1), .REPEAT_CYCLES(REPEAT_CYCLES), .ACTIVE_LOW(0)
    ) dut_a (
        .clk               (clk),
        .rst               (rst),
        .PB                (pb_a),
        .PB_pressed_status (a_status),
        .PB_pressed_pulse  (a_pressed),
        .PB_released_pulse (a_released),
        .PB_long_pulse     (a_long),
        .PB_repeat_pulse   (a_repeat),
        .PB_long_status    (a_long_status)
    );

    pb_debouncer_multi #(
        .N_CH(N_CH), .DELAY(DELAY), .LONG_CYCLES(LONG_CYCLES),
        .REPEAT_EN(0), .REPEAT_CYCLES(REPEAT_CYCLES), .ACTIVE_LOW(1)
    ) dut_b (
        .clk               (clk),
        .rst               (rst),
        .PB                (pb_b),
        .PB_pressed_status (b_status),
        .PB_pressed_pulse  (b_pressed),
        .PB_released_pulse (b_released),
        .PB_long_pulse     (b_long),
        .PB_repeat_pulse   (b_repeat),
        .PB_long_status    (b_long_status)
    );

    assign obs_a = {a_status, a_pressed, a_released, a_long, a_repeat, a_long_status};
    assign obs_b = {b_status, b_pressed, b_released, b_long, b_repeat, b_long_status};

    // Expected {status, pressed, released, long, repeat, long_status} of one
    // channel in cycle r, for a clean button edge at tp (press) and tr
    // (release), both counted in the same cycle numbering as r.
    function automatic logic [5:0] chanExp(input int r, input int tp, input int tr,
                                           input bit rep_en);
        int   press_t;
        int   rel_t;
        int   long_t;
        logic st, pr, rl, lp, rp, ls;
        press_t = tp + PRESS_LAT;
        rel_t   = tr + PRESS_LAT;
        long_t  = press_t + LONG_CYCLES;
        st = (r >= press_t) && (r < rel_t);
        pr = (r == press_t);
        rl = (r == rel_t) && (tp < NEVER);
        lp = (long_t < rel_t) && (r == long_t);
        ls = (long_t < rel_t) && (r >= long_t) && (r < rel_t);
        rp = rep_en && (r > long_t) && (r < rel_t) &&
             (((r - long_t) % REPEAT_CYCLES) == 0);
        return {st, pr, rl, lp, rp, ls};
    endfunction

    function automatic logic [11:0] packExp(input logic [5:0] c0, input logic [5:0] c1);
        return {c1[5], c0[5], c1[4], c0[4], c1[3], c0[3],
                c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
    endfunction

    task automatic applyStimulus(input logic [1:0] new_a, input logic [1:0] new_b,
                                 input logic [11:0] exp_a, input logic [11:0] exp_b);
        exp_t e;
        pb_a = new_a;
        pb_b = new_b;
        e.a  = exp_a;
        e.b  = exp_b;
        exp_q.push_back(e);
    endtask

    task automatic checkNow(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            assert (obs_a === e.a) else begin
                fail_count++;
                $error("[TB] FAIL %s dut_a observed=%b expected=%b", tag, obs_a, e.a);
            end
            tests_run++;
            assert (obs_b === e.b) else begin
                fail_count++;
                $error("[TB] FAIL %s dut_b observed=%b expected=%b", tag, obs_b, e.b);
            end
        end
    endtask

    // Compare at the falling edge of the current cycle, then move to just
    // after the next rising edge, where the next step drives its inputs.
    task automatic checkOutput(input string tag);
        @(negedge clk);
        checkNow(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] pa;
        logic [1:0] pbv;
        logic       b0;

        rst  = 1'b0;
        pb_a = 2'b00;
        pb_b = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(2'b00, 2'b11, ALL_ZERO, ALL_ZERO);
        checkNow("reset_hold");

        // Buttons held while reset releases: both seen as a new press.
        rst = 1'b1;
        for (int r = 0; r <= 12; r++) begin
            applyStimulus(2'b11, 2'b11,
                          packExp(chanExp(r, 0, NEVER, 1), chanExp(r, 0, NEVER, 1)),
                          ALL_ZERO);
            checkOutput($sformatf("reset_release_r%0d", r));
        end

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        applyStimulus(2'b11, 2'b11, ALL_ZERO, ALL_ZERO);
        checkNow("async_reset");
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 2'b11, ALL_ZERO, ALL_ZERO);
        checkOutput("reset_held");
        rst = 1'b1;
        for (int r = 0; r < 8; r++) begin
            applyStimulus(2'b00, 2'b11, ALL_ZERO, ALL_ZERO);
            checkOutput($sformatf("idle_r%0d", r));
        end

        // Clean long hold on channel 0; the repeat due at release is dropped.
        for (int r = 0; r <= 70; r++) begin
            pa = (r < 60) ? 2'b01 : 2'b00;
            applyStimulus(pa, 2'b11, packExp(chanExp(r, 0, 60, 1), IDLE_CH), ALL_ZERO);
            checkOutput($sformatf("long_hold_r%0d", r));
        end

        // Bounce with 3-cycle runs, then settle high, then a short release.
        for (int r = 0; r <= 55; r++) begin
            if (r < 30) b0 = (((r / 3) % 2) == 0);
            else        b0 = (r < 45);
            applyStimulus({1'b0, b0}, 2'b11, packExp(chanExp(r, 30, 45, 1), IDLE_CH),
                          ALL_ZERO);
            checkOutput($sformatf("bounce_r%0d", r));
        end

        // Short presses on both channels, overlapping in time.
        for (int r = 0; r <= 22; r++) begin
            pa[0] = (r >= 2) && (r < 12);
            pa[1] = (r < 10);
            applyStimulus(pa, 2'b11,
                          packExp(chanExp(r, 2, 12, 1), chanExp(r, 0, 10, 1)), ALL_ZERO);
            checkOutput($sformatf("short_r%0d", r));
        end

        // Level falls in exactly the cycle the long pulse would fire.
        for (int r = 0; r <= 32; r++) begin
            pa = (r < 20) ? 2'b01 : 2'b00;
            applyStimulus(pa, 2'b11, packExp(chanExp(r, 0, 20, 1), IDLE_CH), ALL_ZERO);
            checkOutput($sformatf("race_r%0d", r));
        end

        // Active-low instance without repeat: channel 0 held low, channel 1 idle.
        for (int r = 0; r <= 72; r++) begin
            pbv = (r < 60) ? 2'b10 : 2'b11;
            applyStimulus(2'b00, pbv, ALL_ZERO,
                          packExp(chanExp(r, 0, 60, 0), IDLE_CH));
            checkOutput($sformatf("config_r%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
